// File: rtl/tlp_hdr_classifier.sv
// tlp_hdr_classifier: decodes PCIe TLP header DW0 into a class code, payload
// length and malformed flag, and buffers the decoded entries in a FIFO.
// Optional per-class statistics counters are built when TLP_CLS_STATS_EN is defined.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready/in_hdr_dw0      : header input handshake
//   out_valid/out_ready/out_*         : decoded head entry (zeroed when out_valid low)
//   cnt_sel/cnt_clear/cnt_value       : statistics counter readback and clear
module tlp_hdr_classifier #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_hdr_dw0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_class,
  output logic             out_has_data,
  output logic             out_hdr_4dw,
  output logic [10:0]      out_len_dw,
  output logic             out_malformed,
  input  logic [4:0]       cnt_sel,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] cnt_value
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW = 19;

  logic [2:0]    fmt;
  logic [4:0]    typ;
  logic [4:0]    dec_cls;
  logic [10:0]   dec_len;
  logic          dec_mal;
  logic [EW-1:0] dec_entry;

  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic          full, empty, push, pop;
  logic          unused_bits;

  assign unused_bits = ^in_hdr_dw0[23:10];

  // Header decode, first match wins
  always_comb begin
    fmt     = in_hdr_dw0[31:29];
    typ     = in_hdr_dw0[28:24];
    dec_cls = 5'd31;
    if      ((fmt == 3'b000 || fmt == 3'b001) && typ == 5'b00000) dec_cls = 5'd0;
    else if ((fmt == 3'b000 || fmt == 3'b001) && typ == 5'b00001) dec_cls = 5'd1;
    else if ((fmt == 3'b010 || fmt == 3'b011) && typ == 5'b00000) dec_cls = 5'd2;
    else if (fmt == 3'b000 && typ == 5'b00010)                    dec_cls = 5'd3;
    else if (fmt == 3'b010 && typ == 5'b00010)                    dec_cls = 5'd4;
    else if (fmt == 3'b000 && typ == 5'b00100)                    dec_cls = 5'd5;
    else if (fmt == 3'b010 && typ == 5'b00100)                    dec_cls = 5'd6;
    else if (fmt == 3'b000 && typ == 5'b00101)                    dec_cls = 5'd7;
    else if (fmt == 3'b010 && typ == 5'b00101)                    dec_cls = 5'd8;
    else if (fmt == 3'b001 && typ[4:3] == 2'b10)                  dec_cls = 5'd9;
    else if (fmt == 3'b011 && typ[4:3] == 2'b10)                  dec_cls = 5'd10;
    else if (fmt == 3'b000 && typ == 5'b01010)                    dec_cls = 5'd11;
    else if (fmt == 3'b010 && typ == 5'b01010)                    dec_cls = 5'd12;
    else if (fmt == 3'b000 && typ == 5'b01011)                    dec_cls = 5'd13;
    else if (fmt == 3'b010 && typ == 5'b01011)                    dec_cls = 5'd14;
    else if ((fmt == 3'b010 || fmt == 3'b011) && typ == 5'b01100) dec_cls = 5'd15;
    else if ((fmt == 3'b010 || fmt == 3'b011) && typ == 5'b01101) dec_cls = 5'd16;
    else if ((fmt == 3'b010 || fmt == 3'b011) && typ == 5'b01110) dec_cls = 5'd17;
    else if (fmt == 3'b100)                                       dec_cls = 5'd18;

    // Length field 0 encodes 1024 DW
    dec_len = (in_hdr_dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, in_hdr_dw0[9:0]};

    dec_mal = 1'b0;
    if (dec_cls == 5'd31)
      dec_mal = 1'b1;
    else if (dec_cls >= 5'd3 && dec_cls <= 5'd8 && dec_len != 11'd1)
      dec_mal = 1'b1;
    else if (dec_cls == 5'd17 && dec_len != 11'd2 && dec_len != 11'd4 && dec_len != 11'd8)
      dec_mal = 1'b1;

    dec_entry = {dec_cls, fmt[1], fmt[0], dec_len, dec_mal};
  end

  // FIFO: extra pointer bit separates full from empty
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready  = ~rst & ~full;
  assign out_valid = ~rst & ~empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    mem_d    = mem_q;
    if (push)
      mem_d[wr_ptr_q[AW-1:0]] = dec_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head = out_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign {out_class, out_has_data, out_hdr_4dw, out_len_dw, out_malformed} = head;

`ifdef TLP_CLS_STATS_EN
  // Classes 0-18 map to slots 0-18, class 31 to slot 19
  localparam int unsigned NCNT = 20;

  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [CNT_W-1:0] cnt_value_q, cnt_value_d;
  logic [4:0]       inc_idx, sel_idx;

  always_comb begin
    inc_idx = (dec_cls == 5'd31) ? 5'd19 : dec_cls;
    sel_idx = (cnt_sel == 5'd31) ? 5'd19 : cnt_sel;
    cnt_d   = cnt_q;
    if (cnt_clear) begin
      for (int unsigned i = 0; i < NCNT; i++)
        cnt_d[i] = '0;
    end else if (push && cnt_q[inc_idx] != '1) begin
      cnt_d[inc_idx] = cnt_q[inc_idx] + CNT_W'(1);
    end
    cnt_value_d = '0;
    if (cnt_sel <= 5'd18 || cnt_sel == 5'd31)
      cnt_value_d = cnt_q[sel_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCNT; i++)
        cnt_q[i] <= '0;
      cnt_value_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      cnt_value_q <= cnt_value_d;
    end
  end

  assign cnt_value = rst ? '0 : cnt_value_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_sel, cnt_clear};
  assign cnt_value  = '0;
`endif

endmodule

// File: tb/tb_tlp_hdr_classifier.sv
module tb_tlp_hdr_classifier;

  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_hdr_dw0;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_class;
  logic        out_has_data;
  logic        out_hdr_4dw;
  logic [10:0] out_len_dw;
  logic        out_malformed;
  logic [4:0]  cnt_sel;
  logic        cnt_clear;
  logic [1:0]  cnt_value;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] v_dw  [NV];
  logic [19:0] v_exp [NV];

  tlp_hdr_classifier #(.FIFO_DEPTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_hdr_dw0(in_hdr_dw0),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_has_data(out_has_data), .out_hdr_4dw(out_hdr_4dw),
    .out_len_dw(out_len_dw), .out_malformed(out_malformed),
    .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_value(cnt_value)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {valid, class, has_data, hdr_4dw, len_dw, malformed}
  function automatic logic [19:0] obs();
    return {out_valid, out_class, out_has_data, out_hdr_4dw, out_len_dw, out_malformed};
  endfunction

  function automatic logic [19:0] ent(logic [4:0] c, logic hd, logic h4, logic [10:0] len, logic mal);
    return {1'b1, c, hd, h4, len, mal};
  endfunction

  task automatic load_vectors();
    v_dw[0]  = 32'h40000001; v_exp[0]  = ent(5'd2,  1'b1, 1'b0, 11'd1,    1'b0);
    v_dw[1]  = 32'h02000002; v_exp[1]  = ent(5'd3,  1'b0, 1'b0, 11'd2,    1'b1);
    v_dw[2]  = 32'h1F000000; v_exp[2]  = ent(5'd31, 1'b0, 1'b0, 11'd1024, 1'b1);
    v_dw[3]  = 32'h20000000; v_exp[3]  = ent(5'd0,  1'b0, 1'b1, 11'd1024, 1'b0);
    v_dw[4]  = 32'h0A000000; v_exp[4]  = ent(5'd11, 1'b0, 1'b0, 11'd1024, 1'b0);
    v_dw[5]  = 32'h4A000010; v_exp[5]  = ent(5'd12, 1'b1, 1'b0, 11'd16,   1'b0);
    v_dw[6]  = 32'h73000004; v_exp[6]  = ent(5'd10, 1'b1, 1'b1, 11'd4,    1'b0);
    v_dw[7]  = 32'h30000001; v_exp[7]  = ent(5'd9,  1'b0, 1'b1, 11'd1,    1'b0);
    v_dw[8]  = 32'h6E000003; v_exp[8]  = ent(5'd17, 1'b1, 1'b1, 11'd3,    1'b1);
    v_dw[9]  = 32'h4E000008; v_exp[9]  = ent(5'd17, 1'b1, 1'b0, 11'd8,    1'b0);
    v_dw[10] = 32'h950003FF; v_exp[10] = ent(5'd18, 1'b0, 1'b0, 11'd1023, 1'b0);
    v_dw[11] = 32'h45000001; v_exp[11] = ent(5'd8,  1'b1, 1'b0, 11'd1,    1'b0);
    v_dw[12] = 32'h22000001; v_exp[12] = ent(5'd31, 1'b0, 1'b1, 11'd1,    1'b1);
    v_dw[13] = 32'h21000002; v_exp[13] = ent(5'd1,  1'b0, 1'b1, 11'd2,    1'b0);
    v_dw[14] = 32'h04000000; v_exp[14] = ent(5'd5,  1'b0, 1'b0, 11'd1024, 1'b1);
    v_dw[15] = 32'h6D000004; v_exp[15] = ent(5'd16, 1'b1, 1'b1, 11'd4,    1'b0);
    v_dw[16] = 32'hA0000001; v_exp[16] = ent(5'd31, 1'b0, 1'b1, 11'd1,    1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_hdr_dw0 = '0; out_ready = 1'b0;
    cnt_sel = 5'd0; cnt_clear = 1'b0;
    step(); step();
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    vectors++;
    if (obs() !== 20'h0) begin miscompares++; $display("FAIL reset_out got=%h exp=00000", obs()); end
    vectors++;
    if (cnt_value !== 2'd0) begin miscompares++; $display("FAIL reset_cnt got=%0d exp=0", cnt_value); end
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); end
    step();
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_hdr_dw0 = 32'h40000001;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL no_fallthrough got=%b exp=0", out_valid); end
    step();
    in_hdr_dw0 = 32'h02000002;
    #1;
    vectors++;
    if (obs() !== v_exp[0]) begin miscompares++; $display("FAIL basic_first got=%h exp=%h", obs(), v_exp[0]); end
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs() !== v_exp[0]) begin miscompares++; $display("FAIL basic_hold%0d got=%h exp=%h", i, obs(), v_exp[0]); end
      step();
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if (obs() !== v_exp[1]) begin miscompares++; $display("FAIL basic_second got=%h exp=%h", obs(), v_exp[1]); end
    step();
    vectors++;
    if (obs() !== 20'h0) begin miscompares++; $display("FAIL basic_empty got=%h exp=00000", obs()); end
    out_ready = 1'b0;
  endtask

  task automatic test_classes();
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1; in_hdr_dw0 = v_dw[i];
      step();
      in_valid = 1'b0;
      vectors++;
      if (obs() !== v_exp[i]) begin
        miscompares++;
        $display("FAIL class_vec%0d dw=%h got=%h exp=%h", i, v_dw[i], obs(), v_exp[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      vectors++;
      if (obs() !== 20'h0) begin miscompares++; $display("FAIL class_idle%0d got=%h exp=00000", i, obs()); end
    end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_hdr_dw0 = v_dw[i];
      #1;
      vectors++;
      if (in_ready !== (i < 4)) begin miscompares++; $display("FAIL full_in_ready%0d got=%b exp=%b", i, in_ready, (i < 4)); end
      step();
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_no_bypass got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs() !== v_exp[i]) begin miscompares++; $display("FAIL drain%0d got=%h exp=%h", i, obs(), v_exp[i]); end
      step();
    end
    vectors++;
    if (obs() !== 20'h0) begin miscompares++; $display("FAIL drain_empty got=%h exp=00000", obs()); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_hdr_dw0 = v_dw[5];
    step();
    for (int i = 6; i < 12; i++) begin
      in_hdr_dw0 = v_dw[i];
      #1;
      vectors++;
      if (obs() !== v_exp[i-1] || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream%0d got=%h rdy=%b exp=%h rdy=1", i, obs(), in_ready, v_exp[i-1]);
      end
      step();
    end
    in_valid = 1'b0;
    vectors++;
    if (obs() !== v_exp[11]) begin miscompares++; $display("FAIL stream_last got=%h exp=%h", obs(), v_exp[11]); end
    step();
    vectors++;
    if (obs() !== 20'h0) begin miscompares++; $display("FAIL stream_empty got=%h exp=00000", obs()); end
    out_ready = 1'b0;
  endtask

  task automatic push_stream(logic [31:0] dw, int n);
    out_ready = 1'b1;
    in_valid = 1'b1; in_hdr_dw0 = dw;
    for (int i = 0; i < n; i++) step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  task automatic read_cnt(logic [4:0] sel, logic [1:0] exp, string name);
    cnt_sel = sel;
    step(); step();
    vectors++;
    if (cnt_value !== exp) begin miscompares++; $display("FAIL %s got=%0d exp=%0d", name, cnt_value, exp); end
  endtask

  task automatic test_stats();
    rst = 1'b1; step(); rst = 1'b0; step();
`ifdef TLP_CLS_STATS_EN
    push_stream(32'h20000000, 1);
    push_stream(32'h0A000000, 5);
    push_stream(32'h1F000000, 1);
    read_cnt(5'd11, 2'd3, "cnt_cpl_saturate");
    read_cnt(5'd0,  2'd1, "cnt_mrd");
    read_cnt(5'd31, 2'd1, "cnt_unknown");
    read_cnt(5'd20, 2'd0, "cnt_unused_idx");
    read_cnt(5'd2,  2'd0, "cnt_mwr_zero");
    cnt_sel = 5'd11;
    out_ready = 1'b1;
    in_valid = 1'b1; in_hdr_dw0 = 32'h0A000000; cnt_clear = 1'b1;
    step();
    in_valid = 1'b0; cnt_clear = 1'b0;
    out_ready = 1'b0;
    read_cnt(5'd11, 2'd0, "cnt_clear_wins");
    push_stream(32'h0A000000, 1);
    read_cnt(5'd11, 2'd1, "cnt_after_clear");
`else
    push_stream(32'h0A000000, 3);
    read_cnt(5'd11, 2'd0, "cnt_tied_zero");
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_hdr_dw0 = 32'h0A000000;
    step(); step(); step();
    in_valid = 1'b0;
    cnt_sel = 5'd11;
    #1;
    vectors++;
    if (obs() !== v_exp[4]) begin miscompares++; $display("FAIL pre_rst_head got=%h exp=%h", obs(), v_exp[4]); end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || cnt_value !== 2'd0) begin
      miscompares++;
      $display("FAIL rst_held got=v%b r%b c%0d exp=v0 r0 c0", out_valid, in_ready, cnt_value);
    end
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1 || obs() !== 20'h0) begin
      miscompares++;
      $display("FAIL rst_release got=r%b out=%h exp=r1 out=00000", in_ready, obs());
    end
    step();
    vectors++;
    if (cnt_value !== 2'd0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_discard got=c%0d v%b exp=c0 v0", cnt_value, out_valid);
    end
  endtask

  initial begin
    load_vectors();
    test_reset();
    test_basic();
    test_classes();
    test_full();
    test_back_to_back();
    test_stats();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlp_hdr_classifier.md
TLP_HDR_CLASSIFIER -- requirements
Module: tlp_hdr_classifier

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: decoded-entry buffer depth; power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-class statistics counter.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1: in_hdr_dw0 is valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept a header this cycle.
REQ-007 SHALL have port in_hdr_dw0, input, 32: TLP header DW0; fmt=[31:29], type=[28:24], length=[9:0].
REQ-008 SHALL have port out_valid, output, 1: head entry is valid.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the head entry.
REQ-010 SHALL have port out_class, output, 5: class code per REQ-016.
REQ-011 SHALL have port out_has_data, output, 1: fmt[1] of the entry.
REQ-012 SHALL have port out_hdr_4dw, output, 1: fmt[0] of the entry.
REQ-013 SHALL have port out_len_dw, output, 11: payload DW count; length 0 maps to 1024.
REQ-014 SHALL have port out_malformed, output, 1: entry fails the REQ-017 checks.
REQ-015 SHALL have ports cnt_sel (input, 5, counter index), cnt_clear (input, 1, clear all counters) and cnt_value (output, CNT_W, selected counter value).

Function
REQ-016 SHALL classify as follows, first match wins:
- 0 MRd: fmt 000/001, type 00000.
- 1 MRdLk: fmt 000/001, type 00001.
- 2 MWr: fmt 010/011, type 00000.
- 3 IORd: fmt 000, type 00010.
- 4 IOWr: fmt 010, type 00010.
- 5 CfgRd0: fmt 000, type 00100.
- 6 CfgWr0: fmt 010, type 00100.
- 7 CfgRd1: fmt 000, type 00101.
- 8 CfgWr1: fmt 010, type 00101.
- 9 Msg: fmt 001, type 10xxx.
- 10 MsgD: fmt 011, type 10xxx.
- 11 Cpl: fmt 000, type 01010.
- 12 CplD: fmt 010, type 01010.
- 13 CplLk: fmt 000, type 01011.
- 14 CplDLk: fmt 010, type 01011.
- 15 FetchAdd: fmt 010/011, type 01100.
- 16 Swap: fmt 010/011, type 01101.
- 17 CAS: fmt 010/011, type 01110.
- 18 Prefix: fmt 100, any type.
- 31 Unknown: anything else.
REQ-017 SHALL set malformed for: class 31; classes 3-8 with length not equal to 1; class 17 with length not 2, 4 or 8.
REQ-018 SHALL accept a header when in_valid and in_ready are both high, and write the decoded entry into the FIFO at that edge.
REQ-019 SHALL drive in_ready as not-full, with no bypass: when full, in_ready is low even if out_ready is high.
REQ-020 SHALL have latency of exactly 1 cycle from acceptance to out_valid on an empty FIFO; there is no combinational fall-through.
REQ-021 SHALL pop the head when out_valid and out_ready are both high; simultaneous push and pop with the FIFO not full SHALL keep occupancy unchanged.
REQ-022 SHALL hold out_* stable while out_valid is high and out_ready is low.
REQ-023 SHALL wrap read and write pointers modulo FIFO_DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-024 SHALL keep out_class/out_has_data/out_hdr_4dw/out_len_dw/out_malformed at 0 whenever out_valid is low.

Reset
REQ-025 SHALL, while rst is high, set the FIFO empty, out_valid=0, in_ready=0, all out_* to 0, and all counters and cnt_value to 0.
REQ-026 SHALL discard any buffered entries on reset mid-operation; in_ready SHALL be 1 the cycle after rst deasserts.

Configuration
REQ-027 SHALL, with TLP_CLS_STATS_EN defined, keep one saturating CNT_W counter per class (indices 0-18, 31), each incremented on acceptance of a header of that class.
REQ-028 SHALL return 0 on cnt_value for an unused cnt_sel index; cnt_value SHALL be the registered value of the selected counter, 1 cycle after cnt_sel.
REQ-029 SHALL have cnt_clear win over a same-cycle increment (counter becomes 0); counters SHALL hold at 2^CNT_W-1 once reached.
REQ-030 SHALL, without TLP_CLS_STATS_EN, instantiate no counters, tie cnt_value to 0 and keep all ports present.

Verification
REQ-031 SHALL cover: DW0=0x40000001 accepted on an idle FIFO -> next cycle out_valid=1, class=2, has_data=1, len=1, malformed=0.
REQ-032 SHALL cover: DW0=0x02000002 (IORd, length 2) -> class=3, malformed=1; DW0=0x1F000000 -> class=31, malformed=1, len=1024.
REQ-033 SHALL cover: FIFO_DEPTH=4, out_ready=0, 5 back-to-back pushes -> 4 accepted, in_ready=0 after the 4th; out_ready=1 -> entries drain in order.
REQ-034 SHALL cover: a continuous stream with out_ready=1 -> one entry per cycle, occupancy stays 1, no loss or reordering.
REQ-035 SHALL cover: with TLP_CLS_STATS_EN, CNT_W=2, 5 Cpl headers -> cnt_sel=11 reads 3; cnt_clear together with a Cpl accept -> reads 0.
REQ-036 SHALL cover: rst pulsed with 3 entries buffered -> out_valid=0 the next cycle, counters 0, in_ready=1 after release.
